logic_gates: RTL and testbench

Registered bitwise logic-gate unit. It computes AND, OR, NOT(a), NAND, NOR, XOR and XNOR of two WIDTH-bit operands. Results are presented one clock after a valid input. It is used as a leaf primitive and teaching/reference block; with WIDTH=1 it reproduces the classic two-input gate truth table.

---
 rtl/logic_gates_pkg.sv | 17 +
 rtl/logic_gates_cell.sv | 21 ++
 rtl/logic_gates.sv | 107 ++++++++++
 tb/tb_logic_gates.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gates_pkg.sv
// Shared types for the registered bitwise gate unit (logic_gates).
package logic_gates_pkg;

    localparam int WIDTH_MAX = 64;

    // Seven gate values for a single bit lane.
    typedef struct packed {
        logic and_v;
        logic or_v;
        logic not_v;
        logic nand_v;
        logic nor_v;
        logic xor_v;
        logic xnor_v;
    } gate_bit_t;

endpackage

// File: rtl/logic_gates_cell.sv
// Combinational 1-bit gate evaluator; one instance per bit lane of logic_gates.
module logic_gates_cell
    import logic_gates_pkg::*;
(
    input  logic      a,
    input  logic      b,
    output gate_bit_t res
);

    always_comb begin
        res        = '0;
        res.and_v  = a & b;
        res.or_v   = a | b;
        res.not_v  = ~a;
        res.nand_v = ~(a & b);
        res.nor_v  = ~(a | b);
        res.xor_v  = a ^ b;
        res.xnor_v = ~(a ^ b);
    end

endmodule

// File: rtl/logic_gates.sv
// Registered bitwise gate unit, one-cycle latency.
// Define LOGIC_GATES_REDUCE_EN to add registered and/or/xor reductions of a.
module logic_gates
    import logic_gates_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] and_out,
    output logic [WIDTH-1:0] or_out,
    output logic [WIDTH-1:0] not_a,
    output logic [WIDTH-1:0] nand_out,
    output logic [WIDTH-1:0] nor_out,
    output logic [WIDTH-1:0] xor_out,
    output logic [WIDTH-1:0] xnor_out
`ifdef LOGIC_GATES_REDUCE_EN
    ,
    output logic             and_red,
    output logic             or_red,
    output logic             xor_red
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] and_v;
        logic [WIDTH-1:0] or_v;
        logic [WIDTH-1:0] not_v;
        logic [WIDTH-1:0] nand_v;
        logic [WIDTH-1:0] nor_v;
        logic [WIDTH-1:0] xor_v;
        logic [WIDTH-1:0] xnor_v;
    } gate_res_t;

    gate_bit_t bits_d [WIDTH];
    gate_res_t res_d;
    gate_res_t res_p1;
    logic      vld_p1;

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_chk
        $error("logic_gates: WIDTH out of range 1..%0d", WIDTH_MAX);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic_gates_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .res (bits_d[i])
        );
    end

    always_comb begin
        res_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            res_d.and_v[i]  = bits_d[i].and_v;
            res_d.or_v[i]   = bits_d[i].or_v;
            res_d.not_v[i]  = bits_d[i].not_v;
            res_d.nand_v[i] = bits_d[i].nand_v;
            res_d.nor_v[i]  = bits_d[i].nor_v;
            res_d.xor_v[i]  = bits_d[i].xor_v;
            res_d.xnor_v[i] = bits_d[i].xnor_v;
        end
    end

    // ---- stage p1: result register; operands only enter when in_valid is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                res_p1 <= res_d;
            end
        end
    end

    assign out_valid = vld_p1;
    assign and_out   = res_p1.and_v;
    assign or_out    = res_p1.or_v;
    assign not_a     = res_p1.not_v;
    assign nand_out  = res_p1.nand_v;
    assign nor_out   = res_p1.nor_v;
    assign xor_out   = res_p1.xor_v;
    assign xnor_out  = res_p1.xnor_v;

`ifdef LOGIC_GATES_REDUCE_EN
    logic [2:0] red_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_p1 <= '0;
        end else if (in_valid) begin
            red_p1 <= {&a, |a, ^a};
        end
    end

    assign and_red = red_p1[2];
    assign or_red  = red_p1[1];
    assign xor_red = red_p1[0];
`endif

endmodule

// File: tb/tb_logic_gates.sv
// Scoreboard bench for logic_gates at WIDTH=1 and WIDTH=8 (reduction checks under LOGIC_GATES_REDUCE_EN).
module tb_logic_gates;

    typedef struct packed {
        logic [7:0] and_v;
        logic [7:0] or_v;
        logic [7:0] not_v;
        logic [7:0] nand_v;
        logic [7:0] nor_v;
        logic [7:0] xor_v;
        logic [7:0] xnor_v;
        logic [2:0] red;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       iv1, ov1;
    logic [0:0] a1, b1, and1, or1, nota1, nand1, nor1, xor1, xnor1;
    logic       iv8, ov8;
    logic [7:0] a8, b8, and8, or8, nota8, nand8, nor8, xor8, xnor8;
`ifdef LOGIC_GATES_REDUCE_EN
    logic       andr1, orr1, xorr1, andr8, orr8, xorr8;
`endif

    logic_gates #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .out_valid(ov1),
        .and_out(and1), .or_out(or1), .not_a(nota1), .nand_out(nand1),
        .nor_out(nor1), .xor_out(xor1), .xnor_out(xnor1)
`ifdef LOGIC_GATES_REDUCE_EN
        , .and_red(andr1), .or_red(orr1), .xor_red(xorr1)
`endif
    );

    logic_gates #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .out_valid(ov8),
        .and_out(and8), .or_out(or8), .not_a(nota8), .nand_out(nand8),
        .nor_out(nor8), .xor_out(xor8), .xnor_out(xnor8)
`ifdef LOGIC_GATES_REDUCE_EN
        , .and_red(andr8), .or_red(orr8), .xor_red(xorr8)
`endif
    );

    int   total = 0;
    int   bad = 0;
    exp_t q1 [$];
    exp_t q8 [$];
    int   run8 = 0;
    int   max8 = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.and_v  = a & b;
        e.or_v   = a | b;
        e.not_v  = ~a;
        e.nand_v = ~(a & b);
        e.nor_v  = ~(a | b);
        e.xor_v  = a ^ b;
        e.xnor_v = ~(a ^ b);
        e.red    = {&a, |a, ^a};
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ov1"},  {7'b0, ov1}, 8'h00);
        chk({tag, "_and1"}, {7'b0, and1}, 8'h00);
        chk({tag, "_nota1"}, {7'b0, nota1}, 8'h00);
        chk({tag, "_nand1"}, {7'b0, nand1}, 8'h00);
        chk({tag, "_xnor1"}, {7'b0, xnor1}, 8'h00);
        chk({tag, "_ov8"},  {7'b0, ov8}, 8'h00);
        chk({tag, "_nota8"}, nota8, 8'h00);
        chk({tag, "_nor8"}, nor8, 8'h00);
        chk({tag, "_xnor8"}, xnor8, 8'h00);
    endtask

    // Monitor: pops one expectation per presented result.
    always @(negedge clk) begin
        exp_t e;
        if (ov8) run8++; else run8 = 0;
        if (run8 > max8) max8 = run8;
        if (ov1) begin
            if (q1.size() == 0) begin
                chk("w1_unexpected_valid", {7'b0, ov1}, 8'h00);
            end else begin
                e = q1.pop_front();
                chk("w1_and",  {7'b0, and1},  e.and_v);
                chk("w1_or",   {7'b0, or1},   e.or_v);
                chk("w1_not_a", {7'b0, nota1}, e.not_v);
                chk("w1_nand", {7'b0, nand1}, e.nand_v);
                chk("w1_nor",  {7'b0, nor1},  e.nor_v);
                chk("w1_xor",  {7'b0, xor1},  e.xor_v);
                chk("w1_xnor", {7'b0, xnor1}, e.xnor_v);
`ifdef LOGIC_GATES_REDUCE_EN
                chk("w1_red", {5'b0, andr1, orr1, xorr1}, {5'b0, e.red});
`endif
            end
        end
        if (ov8) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_valid", {7'b0, ov8}, 8'h00);
            end else begin
                e = q8.pop_front();
                chk("w8_and",  and8,  e.and_v);
                chk("w8_or",   or8,   e.or_v);
                chk("w8_not_a", nota8, e.not_v);
                chk("w8_nand", nand8, e.nand_v);
                chk("w8_nor",  nor8,  e.nor_v);
                chk("w8_xor",  xor8,  e.xor_v);
                chk("w8_xnor", xnor8, e.xnor_v);
                chk("w8_inv_nand", nand8, ~and8);
                chk("w8_inv_nor",  nor8,  ~or8);
                chk("w8_inv_xnor", xnor8, ~xor8);
`ifdef LOGIC_GATES_REDUCE_EN
                chk("w8_red", {5'b0, andr8, orr8, xorr8}, {5'b0, e.red});
`endif
            end
        end
    end

    // Truth table rows {and,or,not_a,nand,nor,xor,xnor} for (a,b)=00,01,10,11.
    logic [6:0] tt_exp [4] = '{7'b0011101, 7'b0111010, 7'b0101010, 7'b1100001};
    logic [7:0] tv_a [16] = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h3C, 8'h81, 8'h7E, 8'h12,
                              8'hFE, 8'h01, 8'hC3, 8'h96, 8'h4D, 8'hB2, 8'h0F, 8'hE7};
    logic [7:0] tv_b [16] = '{8'hFF, 8'h00, 8'h5A, 8'h5A, 8'hC3, 8'h18, 8'h7F, 8'h34,
                              8'h01, 8'hFF, 8'h3C, 8'h69, 8'hD4, 8'h2B, 8'hF0, 8'h7E};

    initial begin
        exp_t e;
        logic [1:0] ab;
        logic [6:0] row;
        iv1 = 1'b0; a1 = '0; b1 = '0;
        iv8 = 1'b0; a8 = '0; b8 = '0;

        // reset state while held
        repeat (2) step();
        chk_all_zero("rst_init");
        #3 rst_n = 1'b1;
        step();

        // WIDTH=1 truth table
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            row = tt_exp[i];
            a1 = ab[1]; b1 = ab[0]; iv1 = 1'b1;
            e = '0;
            e.and_v = {7'b0, row[6]}; e.or_v = {7'b0, row[5]}; e.not_v = {7'b0, row[4]};
            e.nand_v = {7'b0, row[3]}; e.nor_v = {7'b0, row[2]}; e.xor_v = {7'b0, row[1]};
            e.xnor_v = {7'b0, row[0]}; e.red = {3{ab[1]}};
            q1.push_back(e);
            step();
        end
        iv1 = 1'b0;
        step();
        chk("pre_rst_and1", {7'b0, and1}, 8'h01);

        // asynchronous reset mid-cycle, then release with no valid input
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        #3 rst_n = 1'b1;
        step();
        chk_all_zero("rst_rel1");
        step();
        chk_all_zero("rst_rel2");

        // hold: results keep value while in_valid is low
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        e = '0; e.and_v = 8'h01; e.or_v = 8'h01; e.xnor_v = 8'h01; e.red = 3'b111;
        q1.push_back(e);
        step();
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_and1", {7'b0, and1}, 8'h01);
            chk("hold_ov1", {7'b0, ov1}, 8'h00);
        end

        // WIDTH=8 directed vector
        a8 = 8'hF0; b8 = 8'hCC; iv8 = 1'b1;
        e = '{and_v: 8'hC0, or_v: 8'hFC, not_v: 8'h0F, nand_v: 8'h3F,
              nor_v: 8'h03, xor_v: 8'h3C, xnor_v: 8'hC3, red: 3'b010};
        q8.push_back(e);
        step();

        // unknown operands while idle must not reach the outputs
        iv8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
        step();
        step();
        chk("x_idle_and8", and8, 8'hC0);
        chk("x_idle_xnor8", xnor8, 8'hC3);
        chk("x_idle_ov8", {7'b0, ov8}, 8'h00);

        // full-throughput burst
        for (int i = 0; i < 16; i++) begin
            a8 = tv_a[i]; b8 = tv_b[i]; iv8 = 1'b1;
            q8.push_back(mk(tv_a[i], tv_b[i]));
            step();
        end
        iv8 = 1'b0;
        step();
        step();
        chk("burst_run_len", 8'(max8), 8'd16);

`ifdef LOGIC_GATES_REDUCE_EN
        a8 = 8'hB1; b8 = 8'h00; iv8 = 1'b1;
        e = mk(8'hB1, 8'h00); e.red = 3'b010;
        q8.push_back(e);
        step();
        a8 = 8'hFF; b8 = 8'h0F;
        e = mk(8'hFF, 8'h0F); e.red = 3'b110;
        q8.push_back(e);
        step();
        iv8 = 1'b0;
        step();
`endif

        // drain with a bounded wait
        for (int i = 0; i < 20 && (q1.size() != 0 || q8.size() != 0); i++) step();
        chk("drain_q1", 8'(q1.size()), 8'd0);
        chk("drain_q8", 8'(q8.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
